// File: rtl/delay_pkg.sv
// delay_pkg: shared constants, FSM state encoding and helpers for the delay tap reader.
package delay_pkg;
    localparam int DEF_AWIDTH = 15;
    localparam int DEF_DWIDTH = 16;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a - b : b - a;
    endfunction
endpackage

// File: rtl/delay_slew.sv
// delay_slew: holds the active tap delay; small changes step by one per tick, large ones jump.
module delay_slew
    import delay_pkg::*;
#(
    parameter int AWIDTH         = DEF_AWIDTH,
    parameter int JUMP_THRESHOLD = 64,
    parameter int SLEW_EN        = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              tick_i,
    input  logic [AWIDTH-1:0] target_i,
    output logic [AWIDTH-1:0] active_o,
    output logic              jump_o
);
    logic [AWIDTH-1:0] active_q, active_d;
    always_comb begin
        jump_o   = (SLEW_EN == 0) || (abs_diff(32'(target_i), 32'(active_q)) > 32'(JUMP_THRESHOLD));
        active_d = !tick_i ? active_q :
                   jump_o ? target_i :
                   (target_i > active_q) ? active_q + AWIDTH'(1) :
                   (target_i < active_q) ? active_q - AWIDTH'(1) : active_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) active_q <= AWIDTH'(1);
        else          active_q <= active_d;
    end
    assign active_o = active_q;
endmodule

// File: rtl/delay_tap_reader.sv
// delay_tap_reader: per-sample read of the delay RAM at (write pointer - active delay),
// with slewed delay changes and an unmute trigger on delay jumps.
module delay_tap_reader
    import delay_pkg::*;
#(
    parameter int DWIDTH         = DEF_DWIDTH,
    parameter int AWIDTH         = DEF_AWIDTH,
    parameter int RAM_LATENCY    = 2,
    parameter int JUMP_THRESHOLD = 64,
    parameter int SLEW_EN        = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              sample_tick_i,
    input  logic [AWIDTH-1:0] delay_i,
    input  logic [AWIDTH-1:0] wr_ptr_i,
    output logic              rd_en_o,
    output logic [AWIDTH-1:0] rd_addr_o,
    input  logic [DWIDTH-1:0] rd_data_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              data_valid_o,
    output logic              unmute_trigger_o,
    output logic              busy_o,
    output logic              overrun_o
);
    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_addr_q, rd_addr_d, target, active, tap_addr;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              valid_q, valid_d, unmute_q, unmute_d, accept, jump;

    assign accept = sample_tick_i && (state_q == IDLE);
    assign target = (delay_i == '0) ? AWIDTH'(1) : delay_i;

    delay_slew #(
        .AWIDTH(AWIDTH),
        .JUMP_THRESHOLD(JUMP_THRESHOLD),
        .SLEW_EN(SLEW_EN)
    ) u_slew (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .tick_i(accept),
        .target_i(target),
        .active_o(active),
        .jump_o(jump)
    );

    always_comb begin
        tap_addr  = wr_ptr_q - active;
        state_d   = accept ? ISSUE :
                    (state_q == ISSUE) ? ((RAM_LATENCY == 1) ? CAPTURE : WAIT) :
                    (state_q == WAIT) ? ((cnt_q == 3'd1) ? CAPTURE : WAIT) :
                    (state_q == CAPTURE) ? IDLE : state_q;
        // cnt holds the WAIT cycles still owed before the RAM data is valid
        cnt_d     = (state_q == ISSUE) ? 3'(RAM_LATENCY - 1) :
                    (state_q == WAIT) ? cnt_q - 3'd1 : cnt_q;
        wr_ptr_d  = accept ? wr_ptr_i : wr_ptr_q;
        rd_addr_d = (state_q == ISSUE) ? tap_addr : rd_addr_q;
        data_d    = (state_q == CAPTURE) ? rd_data_i : data_q;
        valid_d   = (state_q == CAPTURE);
        unmute_d  = accept && jump;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_addr_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            unmute_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_addr_q <= rd_addr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            unmute_q  <= unmute_d;
        end
    end

    assign rd_en_o          = (state_q == ISSUE);
    assign rd_addr_o        = rd_en_o ? tap_addr : rd_addr_q;
    assign data_o           = data_q;
    assign data_valid_o     = valid_q;
    assign unmute_trigger_o = unmute_q;
    assign busy_o           = (state_q != IDLE);
    assign overrun_o        = sample_tick_i && busy_o;
endmodule

// File: tb/tb_delay_tap_reader.sv
// tb_delay_tap_reader: scoreboard bench for two reader instances (slewed/latency 2, unslewed/latency 1).
module tb_delay_tap_reader;
    typedef struct {
        int          cyc;
        logic [14:0] addr;
        logic        jump;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic [14:0] delay = '0, wr = '0;
    logic        rd_en[2], valid[2], unmute[2], busy[2], ovr[2];
    logic [14:0] rd_addr[2];
    logic [15:0] rd_data[2], data[2];
    logic [15:0] mem [32768];
    logic [15:0] p0a, p0b, p1a;
    exp_t        qa[2][$];
    exp_t        qd[2][$];
    int          act[2], free[2];
    int          lat[2] = '{2, 1};
    int          cyc = 0, checks = 0, errors = 0;
    logic [14:0] last;

    always #5 clk = ~clk;

    delay_tap_reader #(.RAM_LATENCY(2), .SLEW_EN(1)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .sample_tick_i(tick), .delay_i(delay), .wr_ptr_i(wr),
        .rd_en_o(rd_en[0]), .rd_addr_o(rd_addr[0]), .rd_data_i(rd_data[0]), .data_o(data[0]),
        .data_valid_o(valid[0]), .unmute_trigger_o(unmute[0]), .busy_o(busy[0]), .overrun_o(ovr[0])
    );
    delay_tap_reader #(.RAM_LATENCY(1), .SLEW_EN(0)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .sample_tick_i(tick), .delay_i(delay), .wr_ptr_i(wr),
        .rd_en_o(rd_en[1]), .rd_addr_o(rd_addr[1]), .rd_data_i(rd_data[1]), .data_o(data[1]),
        .data_valid_o(valid[1]), .unmute_trigger_o(unmute[1]), .busy_o(busy[1]), .overrun_o(ovr[1])
    );

    // RAM read pipes; garbage is shifted in when no read is issued
    always @(posedge clk) begin
        p0a <= rd_en[0] ? mem[rd_addr[0]] : 16'($urandom);
        p0b <= p0a;
        p1a <= rd_en[1] ? mem[rd_addr[1]] : 16'($urandom);
    end
    assign rd_data[0] = p0b;
    assign rd_data[1] = p1a;

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d: got %0h expected %0h", nm, k, cyc, got, exp);
        end
    endtask

    task automatic chk_zero();
        for (int k = 0; k < 2; k++) begin
            chk("rst_addr", k, 32'(rd_addr[k]), 0);
            chk("rst_data", k, 32'(data[k]), 0);
            chk("rst_flags", k, 32'({rd_en[k], valid[k], unmute[k], busy[k], ovr[k]}), 0);
        end
    endtask

    // Reference model: acceptance, active-delay rules and expected timing per instance
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                qa[k].delete();
                qd[k].delete();
                act[k]  = 1;
                free[k] = 0;
            end
        end else if (tick) begin
            for (int k = 0; k < 2; k++) begin
                if (cyc >= free[k]) begin
                    int   t, a;
                    exp_t e;
                    t = (delay == 0) ? 1 : int'(delay);
                    a = act[k];
                    e.jump = (k == 1) || ((t > a ? t - a : a - t) > 64);
                    act[k] = e.jump ? t : (t > a ? a + 1 : (t < a ? a - 1 : a));
                    e.addr = 15'((int'(wr) - act[k]) & 32'h7FFF);
                    e.data = mem[e.addr];
                    e.cyc  = cyc;
                    qa[k].push_back(e);
                    free[k] = cyc + lat[k] + 2;
                end
            end
        end
    end

    // Monitor: compares every output each cycle against the scoreboard
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                logic exp_rd, exp_v, exp_busy;
                exp_busy = (cyc + 1 < free[k]);
                chk("busy", k, 32'(busy[k]), 32'(exp_busy));
                chk("overrun", k, 32'(ovr[k]), 32'(tick && exp_busy));
                exp_rd = (qa[k].size() > 0) && (qa[k][0].cyc == cyc);
                chk("rd_en", k, 32'(rd_en[k]), 32'(exp_rd));
                if (exp_rd) begin
                    exp_t e;
                    e = qa[k].pop_front();
                    chk("rd_addr", k, 32'(rd_addr[k]), 32'(e.addr));
                    chk("unmute", k, 32'(unmute[k]), 32'(e.jump));
                    e.cyc = cyc + lat[k] + 1;
                    qd[k].push_back(e);
                end else begin
                    chk("unmute_idle", k, 32'(unmute[k]), 0);
                end
                exp_v = (qd[k].size() > 0) && (qd[k][0].cyc == cyc);
                chk("data_valid", k, 32'(valid[k]), 32'(exp_v));
                if (exp_v) begin
                    exp_t e;
                    e = qd[k].pop_front();
                    chk("data", k, 32'(data[k]), 32'(e.data));
                end
            end
        end
    end

    task automatic tick_once(input logic [14:0] d, input logic [14:0] w, input int gap);
        tick  = 1'b1;
        delay = d;
        wr    = w;
        last  = d;
        @(posedge clk); #1;
        tick  = 1'b0;
        delay = 15'($urandom);
        wr    = 15'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk_zero();
        rst_n = 1'b1;
        @(posedge clk); #1;
        tick_once(15'd500, 15'($urandom), 4);
        tick_once(15'd10, 15'd100, 4);
        tick_once(15'd10, 15'd5, 4);
        tick_once(15'd1000, 15'($urandom), 4);
        tick_once(15'd1001, 15'($urandom), 4);
        for (int i = 0; i < 10; i++) tick_once(15'd1010, 15'($urandom), 4);
        tick_once(15'd2000, 15'($urandom), 4);
        tick_once(15'd2010, 15'($urandom), 0);
        tick_once(15'd3000, 15'($urandom), 4);
        tick_once(15'd2990, 15'($urandom), 1);
        tick_once(15'd3000, 15'($urandom), 4);
        tick_once(15'd0, 15'($urandom), 4);
        tick_once(15'd0, 15'd0, 4);
        // reset while instance 0 sits in WAIT
        tick  = 1'b1;
        delay = 15'd700;
        wr    = 15'($urandom);
        @(posedge clk); #1;
        tick  = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_zero();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        tick_once(15'd5, 15'd200, 4);
        for (int i = 0; i < 300; i++) begin
            logic [14:0] d;
            d = ($urandom_range(0, 3) == 0) ? 15'($urandom)
                                            : 15'(int'(last) + int'($urandom_range(0, 20)) - 10);
            tick_once(d, 15'($urandom), int'($urandom_range(0, 5)));
        end
        repeat (10) begin @(posedge clk); #1; end
        for (int k = 0; k < 2; k++) chk("drain", k, 32'(qa[k].size() + qd[k].size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/delay_tap_reader.md
Name: delay_tap_reader

Overview:
Read side of the delay line memory whose write side is fed by the reflections pipeline. On each sample tick it computes the tap address (write pointer minus active delay), issues one RAM read, and captures the returned sample for the reflections pipeline. It slews small delay-time changes one sample per tick to avoid zipper noise. On large delay jumps it switches immediately and pulses unmute_trigger_o, which drives the pipeline's unmute ramp.

Parameters:
DWIDTH, 16, sample width
AWIDTH, 15, delay RAM address width; depth = 2**AWIDTH
RAM_LATENCY, 2, cycles from rd_en_o to valid rd_data_i (1..7)
JUMP_THRESHOLD, 64, |target-active| above this value is treated as a jump
SLEW_EN, 1, 0 = always jump (no slewing)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
sample_tick_i  in  1  one-cycle strobe per audio sample
delay_i  in  AWIDTH  target delay in samples, sampled at tick
wr_ptr_i  in  AWIDTH  current write address of the delay RAM writer
rd_en_o  out  1  RAM read strobe, one cycle
rd_addr_o  out  AWIDTH  RAM read address
rd_data_i  in  DWIDTH  RAM read data
data_o  out  DWIDTH  tap sample, held until the next capture
data_valid_o  out  1  one-cycle pulse when data_o updates
unmute_trigger_o  out  1  one-cycle pulse on delay jump
busy_o  out  1  high from tick acceptance until capture
overrun_o  out  1  one-cycle pulse when a tick arrives while busy

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; active_delay = 1.
- Clamp the target: delay_i = 0 -> 1; the full AWIDTH range is otherwise legal.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - On sample_tick_i, latch the clamped target and wr_ptr_i, then go to ISSUE.
  - In the same cycle, update active_delay:
    - if SLEW_EN = 0 or |target-active| > JUMP_THRESHOLD: active = target, and unmute_trigger_o pulses in the ISSUE cycle;
    - else if target > active: active + 1;
    - else if target < active: active - 1;
    - else active is unchanged.
- ISSUE:
  - rd_en_o = 1 for exactly one cycle.
  - rd_addr_o = latched wr_ptr - active_delay, modulo 2**AWIDTH (natural wrap).
  - Next state is WAIT, with the latency counter loaded to RAM_LATENCY-1.
- WAIT: count down; at 0 go to CAPTURE. If RAM_LATENCY = 1, go to CAPTURE directly.
- CAPTURE:
  - data_o <= rd_data_i; data_valid_o pulses; return to IDLE.
  - Tick-to-valid latency is RAM_LATENCY+2 cycles.
- busy_o = (state != IDLE).
- A tick while busy is dropped: state and active_delay are unaffected, and overrun_o pulses in that cycle.
- rd_addr_o holds its last value outside ISSUE.
- Jump detection uses the unsigned absolute difference at AWIDTH+1 bits. No signed wrap is involved.
- Reset asserted mid-read: immediate return to IDLE, outputs cleared, and any late rd_data_i is ignored.

Decomposition:
- Package delay_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/CAPTURE);
  - the default AWIDTH/DWIDTH constants;
  - the function abs_diff(a,b).
- Sub-module delay_slew: holds active_delay and produces the jump flag, driven by tick/target. It is testable standalone.

Test Plan:
- Basic read: wr_ptr=100, delay=10, RAM_LATENCY=2 -> rd_addr_o=90 one cycle after tick; data_valid_o 4 cycles after tick with data_o = RAM[90].
- Wrap: wr_ptr=5, delay=10, AWIDTH=15 -> rd_addr_o=32763.
- Slew: active=1000, delay_i=1010, ten ticks -> active steps 1001..1010, with no unmute_trigger_o.
- Jump: active=1000, delay_i=2000 -> active=2000 on the first tick and unmute_trigger_o pulses once; the same case with SLEW_EN=0 and delay_i=1001 also pulses.
- Overrun: two ticks 1 cycle apart -> the second produces an overrun_o pulse, only one rd_en_o occurs, and active_delay changes only once.
- Reset mid-WAIT: drop rst_n_i during WAIT -> all outputs 0 immediately and no data_valid_o afterward. delay_i=0 -> rd_addr_o = wr_ptr-1.
